duck_reg_write_arbiter: RTL and testbench

- Arbitrates write requests from several game-logic requesters into the per-duck position registers (20-bit, {x[9:0], y[9:0]}) and per-duck status registers (2-bit).
- Typical requesters are the game FSM, the motion updater and the hit detector. The block drives the registers' Load/D pins directly.
- Writes are committed only during vertical blanking, so the VGA sprite logic never sees a torn update mid-frame.
- Round-robin fairness; one write per transaction; req/ack handshake.

---
 rtl/duck_reg_write_arbiter.sv | 134 +++++++++++++
 tb/tb_duck_reg_write_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/duck_reg_write_arbiter.sv
// Round-robin write arbiter that commits duck position/status register writes
// only during vertical blanking, one req/ack transaction at a time.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for vblank with at least one request pending
// WRITE | latched data on the D buses, load strobe to the target duck
// ACK   | completion pulse to the winner, round-robin pointer advances
module duck_reg_write_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int NUM_DUCKS = 2,
   parameter int IDX_W     = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     vblank_i,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*IDX_W-1:0] req_idx_i,
   input  logic [NUM_REQ*20-1:0]    req_pos_i,
   input  logic [NUM_REQ*2-1:0]     req_stat_i,
   input  logic [NUM_REQ-1:0]       req_we_pos_i,
   input  logic [NUM_REQ-1:0]       req_we_stat_i,
   output logic [NUM_REQ-1:0]       ack_o,
   output logic [NUM_DUCKS-1:0]     pos_load_o,
   output logic [19:0]              pos_d_o,
   output logic [NUM_DUCKS-1:0]     stat_load_o,
   output logic [1:0]               stat_d_o,
   output logic                     busy_o,
   output logic                     idx_err_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_ACK   = 2'd2;

   localparam logic [NUM_DUCKS-1:0] DUCK_ONE = {{(NUM_DUCKS-1){1'b0}}, 1'b1};
   localparam logic [NUM_REQ-1:0]   REQ_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(NUM_REQ - 1);

   logic [1:0]       state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] win_q;
   logic [IDX_W-1:0] idx_q;
   logic [19:0]      pos_q;
   logic [1:0]       stat_q;
   logic             we_pos_q;
   logic             we_stat_q;

   logic             found;
   logic [PTR_W-1:0] grant;
   logic [PTR_W-1:0] cand;
   logic             grant_en;
   logic             idx_ok;

   // First asserted request scanning upward from rr_ptr with wrap.
   always_comb begin
      found = 1'b0;
      grant = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            grant = cand;
         end
      end
   end

   assign grant_en = (state_q == S_IDLE) && vblank_i && found;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         S_IDLE:  if (grant_en) state_d = S_WRITE;
         S_WRITE: state_d = S_ACK;
         S_ACK: begin
            state_d  = S_IDLE;
            rr_ptr_d = (win_q == PTR_LAST) ? '0 : win_q + PTR_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         win_q     <= '0;
         idx_q     <= '0;
         pos_q     <= '0;
         stat_q    <= '0;
         we_pos_q  <= 1'b0;
         we_stat_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         if (grant_en) begin
            win_q     <= grant;
            idx_q     <= req_idx_i[int'(grant)*IDX_W +: IDX_W];
            pos_q     <= req_pos_i[int'(grant)*20 +: 20];
            stat_q    <= req_stat_i[int'(grant)*2 +: 2];
            we_pos_q  <= req_we_pos_i[grant];
            we_stat_q <= req_we_stat_i[grant];
         end
      end
   end

   // Out-of-range indices produce an error pulse instead of a stray load.
   assign idx_ok = int'(idx_q) < NUM_DUCKS;

   always_comb begin
      pos_load_o  = '0;
      stat_load_o = '0;
      idx_err_o   = 1'b0;
      ack_o       = '0;
      if (state_q == S_WRITE) begin
         if (idx_ok) begin
            if (we_pos_q)  pos_load_o  = DUCK_ONE << idx_q;
            if (we_stat_q) stat_load_o = DUCK_ONE << idx_q;
         end else begin
            idx_err_o = 1'b1;
         end
      end
      if (state_q == S_ACK) ack_o = REQ_ONE << win_q;
   end

   assign pos_d_o  = pos_q;
   assign stat_d_o = stat_q;
   assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_duck_reg_write_arbiter.sv
// Directed bench for duck_reg_write_arbiter: grant order, timing, vblank gating,
// index error and reset abort, with hand-computed expectations.
module tb_duck_reg_write_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        vblank_i;
   logic [2:0]  req_i;
   logic [8:0]  req_idx_i;
   logic [59:0] req_pos_i;
   logic [5:0]  req_stat_i;
   logic [2:0]  req_we_pos_i;
   logic [2:0]  req_we_stat_i;
   logic [2:0]  ack_o;
   logic [1:0]  pos_load_o;
   logic [19:0] pos_d_o;
   logic [1:0]  stat_load_o;
   logic [1:0]  stat_d_o;
   logic        busy_o;
   logic        idx_err_o;

   int n_tests = 0;
   int n_fail  = 0;

   duck_reg_write_arbiter #(.NUM_REQ(3), .NUM_DUCKS(2), .IDX_W(3)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .vblank_i      (vblank_i),
      .req_i         (req_i),
      .req_idx_i     (req_idx_i),
      .req_pos_i     (req_pos_i),
      .req_stat_i    (req_stat_i),
      .req_we_pos_i  (req_we_pos_i),
      .req_we_stat_i (req_we_stat_i),
      .ack_o         (ack_o),
      .pos_load_o    (pos_load_o),
      .pos_d_o       (pos_d_o),
      .stat_load_o   (stat_load_o),
      .stat_d_o      (stat_d_o),
      .busy_o        (busy_o),
      .idx_err_o     (idx_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input int r, input logic [2:0] idx, input logic [19:0] pos,
                          input logic [1:0] stat, input logic wep, input logic wes);
      req_idx_i[r*3 +: 3]   = idx;
      req_pos_i[r*20 +: 20] = pos;
      req_stat_i[r*2 +: 2]  = stat;
      req_we_pos_i[r]       = wep;
      req_we_stat_i[r]      = wes;
   endtask

   // Grant edge, WRITE cycle, ACK cycle; winner drops req after its ack.
   task automatic xact(input string tag, input logic [2:0] ack_exp, input logic [1:0] pl,
                       input logic [1:0] sl, input logic [19:0] pd, input logic [1:0] sd,
                       input logic err, input logic drop_vb);
      tick();
      if (drop_vb) vblank_i = 1'b0;
      chk({tag, "_pos_load"}, pos_load_o, pl);
      chk({tag, "_stat_load"}, stat_load_o, sl);
      chk({tag, "_pos_d"}, pos_d_o, pd);
      chk({tag, "_stat_d"}, stat_d_o, sd);
      chk({tag, "_idx_err"}, idx_err_o, err);
      chk({tag, "_wr_busy"}, busy_o, 1'b1);
      chk({tag, "_wr_ack"}, ack_o, 3'b000);
      tick();
      chk({tag, "_ack"}, ack_o, ack_exp);
      chk({tag, "_ack_busy"}, busy_o, 1'b1);
      chk({tag, "_ack_loads"}, {pos_load_o, stat_load_o, idx_err_o}, 5'b0);
      req_i = req_i & ~ack_exp;
      tick();
      chk({tag, "_idle_busy"}, busy_o, 1'b0);
      chk({tag, "_idle_ack"}, ack_o, 3'b000);
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      tick();
      tick();
      rst_n_i = 1'b1;
   endtask

   initial begin
      int bad;
      rst_n_i = 1'b0; vblank_i = 1'b0; req_i = '0;
      req_idx_i = '0; req_pos_i = '0; req_stat_i = '0;
      req_we_pos_i = '0; req_we_stat_i = '0;
      tick();
      tick();
      chk("rst_outputs", {ack_o, pos_load_o, stat_load_o, busy_o, idx_err_o}, 10'b0);
      chk("rst_pos_d", pos_d_o, 20'h0);
      chk("rst_stat_d", stat_d_o, 2'b00);
      rst_n_i = 1'b1;
      tick();

      // Single write to duck 1 from requester 0.
      set_req(0, 3'd1, 20'hABCDE, 2'b10, 1'b1, 1'b1);
      vblank_i = 1'b1; req_i = 3'b001;
      xact("t1", 3'b001, 2'b10, 2'b10, 20'hABCDE, 2'b10, 1'b0, 1'b0);
      chk("t1_hold_pos_d", pos_d_o, 20'hABCDE);

      // No grants outside vblank, then strict round-robin from pointer 0.
      do_reset();
      vblank_i = 1'b0;
      set_req(0, 3'd0, 20'h11111, 2'b01, 1'b1, 1'b1);
      set_req(1, 3'd1, 20'h22222, 2'b10, 1'b1, 1'b0);
      set_req(2, 3'd1, 20'h33333, 2'b11, 1'b0, 1'b1);
      req_i = 3'b111;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (busy_o || ack_o != 0 || pos_load_o != 0 || stat_load_o != 0) bad++;
      end
      chk("novb_activity", bad, 0);
      vblank_i = 1'b1;
      xact("rr0", 3'b001, 2'b01, 2'b01, 20'h11111, 2'b01, 1'b0, 1'b0);
      xact("rr1", 3'b010, 2'b10, 2'b00, 20'h22222, 2'b10, 1'b0, 1'b0);
      xact("rr2", 3'b100, 2'b00, 2'b10, 20'h33333, 2'b11, 1'b0, 1'b0);

      // Pointer at 1 after serving req0: req2 wins over req0.
      set_req(0, 3'd0, 20'h0AAAA, 2'b01, 1'b1, 1'b0);
      req_i = 3'b001;
      xact("p1_r0", 3'b001, 2'b01, 2'b00, 20'h0AAAA, 2'b01, 1'b0, 1'b0);
      set_req(2, 3'd0, 20'h0CCCC, 2'b11, 1'b0, 1'b1);
      req_i = 3'b101;
      xact("p1_r2", 3'b100, 2'b00, 2'b01, 20'h0CCCC, 2'b11, 1'b0, 1'b0);
      xact("p1_r0b", 3'b001, 2'b01, 2'b00, 20'h0AAAA, 2'b01, 1'b0, 1'b0);

      // Out-of-range index: error pulse, no loads, still acked.
      set_req(1, 3'd5, 20'h55555, 2'b01, 1'b1, 1'b1);
      req_i = 3'b010;
      xact("idx5", 3'b010, 2'b00, 2'b00, 20'h55555, 2'b01, 1'b1, 1'b0);

      // vblank falls right after grant; pending req1 waits for next vblank.
      set_req(0, 3'd1, 20'h76543, 2'b00, 1'b1, 1'b1);
      set_req(1, 3'd0, 20'h12345, 2'b11, 1'b1, 1'b1);
      req_i = 3'b011;
      xact("vbdrop", 3'b001, 2'b10, 2'b10, 20'h76543, 2'b00, 1'b0, 1'b1);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (busy_o || ack_o != 0) bad++;
      end
      chk("vbdrop_wait", bad, 0);
      vblank_i = 1'b1;
      xact("vbnext", 3'b010, 2'b01, 2'b01, 20'h12345, 2'b11, 1'b0, 1'b0);

      // Reset during WRITE for req2; afterwards req0 wins from pointer 0.
      set_req(0, 3'd0, 20'h0F0F0, 2'b10, 1'b1, 1'b1);
      set_req(2, 3'd1, 20'h0E0E0, 2'b01, 1'b1, 1'b1);
      req_i = 3'b101;
      tick();
      chk("rstw_pre_load", pos_load_o, 2'b10);
      rst_n_i = 1'b0;
      #1;
      chk("rstw_now", {ack_o, pos_load_o, stat_load_o, busy_o}, 8'b0);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ack_o != 0 || busy_o) bad++;
      end
      chk("rstw_no_ack", bad, 0);
      rst_n_i = 1'b1;
      xact("rstw_r0", 3'b001, 2'b01, 2'b01, 20'h0F0F0, 2'b10, 1'b0, 1'b0);
      xact("rstw_r2", 3'b100, 2'b10, 2'b10, 20'h0E0E0, 2'b01, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
